branch_ctrl: RTL and testbench

Multicycle sequencer for conditional branches in the 64-bit core. On a branch issue it drives the shared ALU through a compare step and a target-address step. It programs the 2-bit select of the branch-condition mux and samples that mux's 1-bit result. It then issues a single PC write and keeps wrap-around branch statistics.

---
 rtl/branch_pkg.sv | 34 +++
 rtl/branch_ctrl_if.sv | 30 +++
 rtl/branch_decode.sv | 19 +
 rtl/branch_ctrl.sv | 151 +++++++++++++++
 tb/tb_branch_ctrl.sv | 145 ++++++++++++++
 5 files changed

// File: rtl/branch_pkg.sv
// Shared types and encodings for the conditional-branch sequencer.
package branch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CMP  = 2'b01,
    ST_TGT  = 2'b10,
    ST_WB   = 2'b11
  } state_t;

  localparam logic       ALU_A_RS1  = 1'b0;
  localparam logic       ALU_A_PC   = 1'b1;
  localparam logic [1:0] ALU_B_RS2  = 2'b00;
  localparam logic [1:0] ALU_B_IMM  = 2'b01;
  localparam logic [1:0] ALU_B_FOUR = 2'b10;
  localparam logic [1:0] ALU_ADD    = 2'b00;
  localparam logic [1:0] ALU_SUB    = 2'b01;

  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;
  localparam logic [2:0] F3_BLT = 3'b100;
  localparam logic [2:0] F3_BGE = 3'b101;

  localparam logic [1:0] COND_Z  = 2'b00;
  localparam logic [1:0] COND_NZ = 2'b01;
  localparam logic [1:0] COND_GE = 2'b10;
  localparam logic [1:0] COND_LT = 2'b11;

  typedef struct packed {
    logic [1:0] cond_sel;
    logic       illegal;
  } decode_t;

endpackage

// File: rtl/branch_ctrl_if.sv
// Control/status bundle between the branch sequencer and the datapath.
interface branch_ctrl_if #(parameter int unsigned CNT_W = 32) ();
  logic             start;
  logic [2:0]       funct3;
  logic             ready;
  logic             alu_a_sel;
  logic [1:0]       alu_b_sel;
  logic [1:0]       alu_op;
  logic [1:0]       cond_sel;
  logic             cond_in;
  logic             pc_write;
  logic             taken;
  logic             flush;
  logic             illegal;
  logic             done;
  logic [CNT_W-1:0] br_count;
  logic [CNT_W-1:0] tk_count;

  modport master (
    output start, funct3, cond_in,
    input  ready, alu_a_sel, alu_b_sel, alu_op, cond_sel, pc_write,
           taken, flush, illegal, done, br_count, tk_count
  );

  modport slave (
    input  start, funct3, cond_in,
    output ready, alu_a_sel, alu_b_sel, alu_op, cond_sel, pc_write,
           taken, flush, illegal, done, br_count, tk_count
  );
endinterface

// File: rtl/branch_decode.sv
// funct3 to condition-mux select; unsupported encodings flag illegal with select 00.
module branch_decode
  import branch_pkg::*;
(
  input  logic [2:0] i_funct3,
  output decode_t    o_dec
);
  always_comb begin
    o_dec.cond_sel = COND_Z;
    o_dec.illegal  = 1'b0;
    case (i_funct3)
      F3_BEQ:  o_dec.cond_sel = COND_Z;
      F3_BNE:  o_dec.cond_sel = COND_NZ;
      F3_BGE:  o_dec.cond_sel = COND_GE;
      F3_BLT:  o_dec.cond_sel = COND_LT;
      default: o_dec.illegal  = 1'b1;
    endcase
  end
endmodule

// File: rtl/branch_ctrl.sv
// Four-state branch sequencer: compare, target, write-back, with wrap-around statistics.
// Outputs are registered from the next state so they align with the state they describe.
module branch_ctrl
  import branch_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic          clk,
  input  logic          reset,
  branch_ctrl_if.slave  bus
);

  state_t           r_state, w_state_nxt;
  logic [1:0]       r_cond_sel_q, w_cond_sel_q_nxt;
  logic             r_illegal_q, w_illegal_q_nxt;
  logic             r_taken_q, w_taken_q_nxt;
  logic [CNT_W-1:0] r_br_count, w_br_count_nxt;
  logic [CNT_W-1:0] r_tk_count, w_tk_count_nxt;

  logic       r_ready, w_ready;
  logic       r_alu_a_sel, w_alu_a_sel;
  logic [1:0] r_alu_b_sel, w_alu_b_sel;
  logic [1:0] r_alu_op, w_alu_op;
  logic [1:0] r_cond_sel, w_cond_sel;
  logic       r_pc_write, w_pc_write;
  logic       r_taken, w_taken;
  logic       r_flush, w_flush;
  logic       r_illegal, w_illegal;
  logic       r_done, w_done;

  decode_t w_dec;

  branch_decode u_decode (
    .i_funct3 (bus.funct3),
    .o_dec    (w_dec)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_cond_sel_q <= 2'b00;
      r_illegal_q  <= 1'b0;
      r_taken_q    <= 1'b0;
      r_br_count   <= '0;
      r_tk_count   <= '0;
      r_ready      <= 1'b1;
      r_alu_a_sel  <= 1'b0;
      r_alu_b_sel  <= 2'b00;
      r_alu_op     <= 2'b00;
      r_cond_sel   <= 2'b00;
      r_pc_write   <= 1'b0;
      r_taken      <= 1'b0;
      r_flush      <= 1'b0;
      r_illegal    <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cond_sel_q <= w_cond_sel_q_nxt;
      r_illegal_q  <= w_illegal_q_nxt;
      r_taken_q    <= w_taken_q_nxt;
      r_br_count   <= w_br_count_nxt;
      r_tk_count   <= w_tk_count_nxt;
      r_ready      <= w_ready;
      r_alu_a_sel  <= w_alu_a_sel;
      r_alu_b_sel  <= w_alu_b_sel;
      r_alu_op     <= w_alu_op;
      r_cond_sel   <= w_cond_sel;
      r_pc_write   <= w_pc_write;
      r_taken      <= w_taken;
      r_flush      <= w_flush;
      r_illegal    <= w_illegal;
      r_done       <= w_done;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_cond_sel_q_nxt = r_cond_sel_q;
    w_illegal_q_nxt  = r_illegal_q;
    w_taken_q_nxt    = r_taken_q;
    w_br_count_nxt   = r_br_count;
    w_tk_count_nxt   = r_tk_count;
    w_ready          = 1'b0;
    w_alu_a_sel      = 1'b0;
    w_alu_b_sel      = 2'b00;
    w_alu_op         = 2'b00;
    w_cond_sel       = 2'b00;
    w_pc_write       = 1'b0;
    w_taken          = 1'b0;
    w_flush          = 1'b0;
    w_illegal        = 1'b0;
    w_done           = 1'b0;

    case (r_state)
      ST_IDLE: if (bus.start) begin
        w_state_nxt      = ST_CMP;
        w_cond_sel_q_nxt = w_dec.cond_sel;
        w_illegal_q_nxt  = w_dec.illegal;
      end
      ST_CMP: begin
        w_taken_q_nxt = bus.cond_in & ~r_illegal_q;
        w_state_nxt   = ST_TGT;
      end
      ST_TGT: w_state_nxt = ST_WB;
      ST_WB: begin
        w_br_count_nxt = r_br_count + CNT_W'(1);
        w_tk_count_nxt = r_tk_count + CNT_W'(r_taken_q);
        w_state_nxt    = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    // Moore outputs of the state being entered, registered at the same edge.
    case (w_state_nxt)
      ST_IDLE: w_ready = 1'b1;
      ST_CMP: begin
        w_alu_op    = ALU_SUB;
        w_alu_a_sel = ALU_A_RS1;
        w_alu_b_sel = ALU_B_RS2;
        w_cond_sel  = w_cond_sel_q_nxt;
      end
      ST_TGT: begin
        w_alu_op    = ALU_ADD;
        w_alu_a_sel = ALU_A_PC;
        w_alu_b_sel = w_taken_q_nxt ? ALU_B_IMM : ALU_B_FOUR;
        w_pc_write  = 1'b1;
        w_flush     = w_taken_q_nxt;
      end
      ST_WB: begin
        w_done    = 1'b1;
        w_taken   = w_taken_q_nxt;
        w_illegal = w_illegal_q_nxt;
      end
      default: w_ready = 1'b0;
    endcase
  end

  assign bus.ready     = r_ready;
  assign bus.alu_a_sel = r_alu_a_sel;
  assign bus.alu_b_sel = r_alu_b_sel;
  assign bus.alu_op    = r_alu_op;
  assign bus.cond_sel  = r_cond_sel;
  assign bus.pc_write  = r_pc_write;
  assign bus.taken     = r_taken;
  assign bus.flush     = r_flush;
  assign bus.illegal   = r_illegal;
  assign bus.done      = r_done;
  assign bus.br_count  = r_br_count;
  assign bus.tk_count  = r_tk_count;

endmodule

// File: tb/tb_branch_ctrl.sv
// Directed and random branches against a per-branch timeline model of the sequencer.
module tb_branch_ctrl;
  localparam int unsigned CW = 4;

  logic clk = 1'b0;
  logic reset;
  int total = 0;
  int bad   = 0;
  int m_br  = 0;
  int m_tk  = 0;

  branch_ctrl_if #(.CNT_W(CW)) bus ();

  branch_ctrl #(.CNT_W(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Condition-mux select a legal branch must present; -1 marks unsupported funct3.
  function automatic int exp_sel(input logic [2:0] f3);
    case (f3)
      3'd0: return 0;
      3'd1: return 1;
      3'd5: return 2;
      3'd4: return 3;
      default: return -1;
    endcase
  endfunction

  // Entered and left on a falling edge with the DUT idle; cycle 0 is the issue cycle.
  task automatic run_branch(input logic [2:0] f3, input logic cin);
    int  sel;
    bit  legal;
    bit  tk;
    sel   = exp_sel(f3);
    legal = (sel >= 0);
    tk    = legal && cin;
    check("c0_ready", 32'(bus.ready), 32'd1);
    bus.start = 1'b1; bus.funct3 = f3; bus.cond_in = ~cin;
    @(negedge clk);
    bus.start = 1'b0; bus.funct3 = 3'($urandom_range(0, 7));
    check("c1_ready", 32'(bus.ready), 32'd0);
    check("c1_ctrl", {28'd0, bus.alu_op, bus.alu_a_sel, bus.pc_write}, {28'd0, 2'b01, 1'b0, 1'b0});
    check("c1_bsel", 32'(bus.alu_b_sel), 32'd0);
    check("c1_cond_sel", 32'(bus.cond_sel), legal ? 32'(sel) : 32'd0);
    bus.cond_in = cin;
    @(negedge clk);
    bus.cond_in = ~cin;
    check("c2_pcw", {30'd0, bus.pc_write, bus.flush}, {30'd0, 1'b1, tk});
    check("c2_alu", {28'd0, bus.alu_op, bus.alu_a_sel, bus.done}, {28'd0, 2'b00, 1'b1, 1'b0});
    check("c2_bsel", 32'(bus.alu_b_sel), tk ? 32'd1 : 32'd2);
    check("c2_cond_sel", 32'(bus.cond_sel), 32'd0);
    @(negedge clk);
    check("c3_done", {29'd0, bus.done, bus.taken, bus.illegal}, {29'd0, 1'b1, tk, !legal});
    check("c3_pcw", {30'd0, bus.pc_write, bus.ready}, 32'd0);
    m_br = (m_br + 1) % (1 << CW);
    if (tk) m_tk = (m_tk + 1) % (1 << CW);
    @(negedge clk);
    check("c4_ready", {30'd0, bus.ready, bus.done}, {30'd0, 1'b1, 1'b0});
    check("c4_br_count", 32'(bus.br_count), 32'(m_br));
    check("c4_tk_count", 32'(bus.tk_count), 32'(m_tk));
  endtask

  initial begin
    int dones;
    reset = 1'b1;
    bus.start = 1'b0; bus.funct3 = 3'd0; bus.cond_in = 1'b0;
    #1;
    check("rst_ready", 32'(bus.ready), 32'd1);
    check("rst_outs", {22'd0, bus.alu_a_sel, bus.alu_b_sel, bus.alu_op, bus.cond_sel,
                       bus.pc_write, bus.taken, bus.flush, bus.illegal, bus.done}, 32'd0);
    check("rst_counts", {24'd0, bus.br_count, bus.tk_count}, 32'd0);
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    run_branch(3'b000, 1'b1);   // BEQ taken
    run_branch(3'b100, 1'b0);   // BLT not taken
    run_branch(3'b010, 1'b1);   // unsupported funct3
    run_branch(3'b101, 1'b1);   // BGE taken
    run_branch(3'b001, 1'b0);   // BNE not taken

    // start held high for 12 cycles
    dones = 0;
    bus.funct3 = 3'b001; bus.cond_in = 1'b0; bus.start = 1'b1;
    for (int k = 0; k < 12; k++) begin
      check($sformatf("held_ready_%0d", k), 32'(bus.ready), (k % 4 == 0) ? 32'd1 : 32'd0);
      check($sformatf("held_done_%0d", k), 32'(bus.done), (k % 4 == 3) ? 32'd1 : 32'd0);
      if (bus.done) dones++;
      @(negedge clk);
    end
    bus.start = 1'b0;
    m_br = (m_br + 3) % (1 << CW);
    check("held_dones", 32'(dones), 32'd3);
    check("held_br_count", 32'(bus.br_count), 32'(m_br));
    check("held_tk_count", 32'(bus.tk_count), 32'(m_tk));

    // reset in the middle of TGT
    bus.start = 1'b1; bus.funct3 = 3'b000; bus.cond_in = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    check("mid_pcw_before", 32'(bus.pc_write), 32'd1);
    reset = 1'b1;
    #1;
    check("mid_pcw_after", {30'd0, bus.pc_write, bus.flush}, 32'd0);
    check("mid_ready", 32'(bus.ready), 32'd1);
    check("mid_outs", {23'd0, bus.alu_a_sel, bus.alu_b_sel, bus.alu_op, bus.cond_sel,
                       bus.done, bus.taken}, 32'd0);
    m_br = 0; m_tk = 0;
    @(negedge clk);
    reset = 1'b0;
    dones = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (bus.done) dones++;
    end
    check("mid_no_done", 32'(dones), 32'd0);
    check("mid_counts", {24'd0, bus.br_count, bus.tk_count}, 32'd0);

    // random branches; enough of them to wrap the narrow counters
    for (int n = 0; n < 40; n++)
      run_branch(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "timeout");
  end
endmodule
